// File: rtl/pc_pkg.sv
// Shared types and default parameters for the Mini-MIPS fetch-stage program counter.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_SEQ   = 3'd0,
      SRC_STALL = 3'd1,
      SRC_BR    = 3'd2,
      SRC_RET   = 3'd3,
      SRC_CALL  = 3'd4,
      SRC_JMP   = 3'd5,
      SRC_EXC   = 3'd6,
      SRC_RESET = 3'd7
   } pc_src_t;

   localparam int PC_W_DEF      = 11;
   localparam int RAS_DEPTH_DEF = 4;
   localparam int RESET_PC_DEF  = 0;
   localparam int EXC_VEC_DEF   = 2040;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module ras_stack #(
   parameter int W     = 11,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         overflow
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign overflow = push && full && !clear;
   // wr_ptr always points one past the newest entry; wrap is free at power-of-two depth
   assign top      = mem[wr_ptr - PTR_W'(1)];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (!full) count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         wr_ptr <= wr_ptr - PTR_W'(1);
         count  <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection with return-address stack,
// exception PC capture and a registered cause code.
module pc_unit
   import pc_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int RESET_PC  = RESET_PC_DEF,
   parameter int EXC_VEC   = EXC_VEC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            exc,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp,
   input  logic            call,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            ret,
   input  logic [PC_W-1:0] ret_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   output logic [PC_W-1:0] epc,
   output logic [2:0]      pc_src,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   localparam logic [PC_W-1:0] EXC_ADDR   = PC_W'(EXC_VEC);
   localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);

   logic [PC_W-1:0] pc_reg, pc_next;
   logic [PC_W-1:0] epc_reg, epc_next;
   pc_src_t         src_reg, src_next;
   logic            ovf_reg;
   logic            unf_reg, unf_next;

   logic            ras_push, ras_pop, ras_clear, ras_overflow;
   logic [PC_W-1:0] ras_top;

   assign pc       = pc_reg;
   assign pc_plus1 = pc_reg + PC_W'(1);
   assign epc      = epc_reg;
   assign pc_src   = src_reg;
   assign ras_ovf  = ovf_reg;
   assign ras_unf  = unf_reg;

   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .clear     (ras_clear),
      .push_data (pc_plus1),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

   // Only the winning request has any side effect on the stack.
   always_comb begin
      pc_next   = pc_plus1;
      epc_next  = epc_reg;
      src_next  = SRC_SEQ;
      unf_next  = 1'b0;
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      ras_clear = 1'b0;
      if (exc) begin
         pc_next   = EXC_ADDR;
         epc_next  = pc_reg;
         src_next  = SRC_EXC;
         ras_clear = 1'b1;
      end else if (stall) begin
         pc_next  = pc_reg;
         src_next = SRC_STALL;
      end else if (br_taken) begin
         pc_next  = br_target;
         src_next = SRC_BR;
      end else if (ret) begin
         src_next = SRC_RET;
         if (ras_empty) begin
            pc_next  = ret_target;
            unf_next = 1'b1;
         end else begin
            pc_next = ras_top;
            ras_pop = 1'b1;
         end
      end else if (call) begin
         pc_next  = jmp_target;
         src_next = SRC_CALL;
         ras_push = 1'b1;
      end else if (jmp) begin
         pc_next  = jmp_target;
         src_next = SRC_JMP;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg  <= RESET_ADDR;
         epc_reg <= '0;
         src_reg <= SRC_RESET;
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         pc_reg  <= pc_next;
         epc_reg <= epc_next;
         src_reg <= src_next;
         unf_reg <= unf_next;
         if (ras_overflow) ovf_reg <= 1'b1;
      end
   end

endmodule
